// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: halt codes, reset level,
// FSM state encoding and a saturating counter helper.
package pipe_ctrl_pkg;

  localparam logic [1:0] HALT_RUN   = 2'b00;
  localparam logic [1:0] HALT_FRONT = 2'b01;
  localparam logic [1:0] HALT_ALL   = 2'b11;

  localparam logic RST_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_FLUSH    = 2'b01,
    ST_MEM_WAIT = 2'b10
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall-request / halt-control bundle between the pipeline stages and pipe_ctrl.
// Performance counter signals exist only when PIPE_PERF_EN is defined.
interface pipe_ctrl_if;

  logic        if_stall_req;
  logic        id_stall_req;
  logic        ex_branch_taken;
  logic        mem_stall_req;
  logic [1:0]  halt_type;
  logic        IFID_discard;
  logic        IDEX_discard;
  logic        stall_timeout;
`ifdef PIPE_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  modport master (
    output if_stall_req, id_stall_req, ex_branch_taken, mem_stall_req,
    input  halt_type, IFID_discard, IDEX_discard, stall_timeout,
    input  stall_cycles, flush_count
  );

  modport slave (
    input  if_stall_req, id_stall_req, ex_branch_taken, mem_stall_req,
    output halt_type, IFID_discard, IDEX_discard, stall_timeout,
    output stall_cycles, flush_count
  );
`else
  modport master (
    output if_stall_req, id_stall_req, ex_branch_taken, mem_stall_req,
    input  halt_type, IFID_discard, IDEX_discard, stall_timeout
  );

  modport slave (
    input  if_stall_req, id_stall_req, ex_branch_taken, mem_stall_req,
    output halt_type, IFID_discard, IDEX_discard, stall_timeout
  );
`endif

endinterface

// File: rtl/pipe_perf_cnt.sv
// Stall-cycle and accepted-redirect counters (32-bit, wrapping); built only under PIPE_PERF_EN.
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_active_i,
  input  logic        redirect_i,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_count_o
);

  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Next-count logic
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (halt_active_i) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if (redirect_i) begin
      flush_count_d = flush_count_q + 32'd1;
    end else begin
      flush_count_d = flush_count_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: Mealy outputs from state + requests, post-redirect flush
// window and sticky memory-stall timeout. Optional counters under PIPE_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam logic [2:0]  FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LIM  = 16'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [15:0] mem_cnt_q, mem_cnt_d;
  logic        stall_timeout_q, stall_timeout_d;
  logic [1:0]  halt_s;
  logic        ifid_discard_s;
  logic        idex_discard_s;
  logic        redirect_s;
  logic        window_s;

  // flush_cnt is nonzero only in FLUSH, or in MEM_WAIT when a stall interrupted a window
  assign window_s = (state_q != ST_RUN) && (flush_cnt_q != 3'd0);

  // Next-state and output decode, highest-priority request first
  always_comb begin
    state_d         = state_q;
    flush_cnt_d     = flush_cnt_q;
    mem_cnt_d       = 16'd0;
    stall_timeout_d = stall_timeout_q;
    halt_s          = HALT_RUN;
    ifid_discard_s  = 1'b0;
    idex_discard_s  = 1'b0;
    redirect_s      = 1'b0;
    if (rst == RST_ENABLE) begin
      ifid_discard_s = 1'b1;
      idex_discard_s = 1'b1;
      state_d        = ST_RUN;
    end else if (bus.mem_stall_req) begin
      halt_s    = HALT_ALL;
      state_d   = ST_MEM_WAIT;
      mem_cnt_d = sat_inc16(mem_cnt_q);
      if (mem_cnt_d >= TIMEOUT_LIM) begin
        stall_timeout_d = 1'b1;
      end else begin
        stall_timeout_d = stall_timeout_q;
      end
    end else if (bus.ex_branch_taken) begin
      ifid_discard_s = 1'b1;
      idex_discard_s = 1'b1;
      redirect_s     = 1'b1;
      flush_cnt_d    = FLUSH_RELOAD;
      state_d        = (FLUSH_RELOAD != 3'd0) ? ST_FLUSH : ST_RUN;
    end else if (window_s) begin
      ifid_discard_s = 1'b1;
      flush_cnt_d    = flush_cnt_q - 3'd1;
      state_d        = (flush_cnt_d != 3'd0) ? ST_FLUSH : ST_RUN;
    end else if (bus.id_stall_req || bus.if_stall_req) begin
      halt_s         = HALT_FRONT;
      idex_discard_s = 1'b1;
      state_d        = ST_RUN;
    end else begin
      state_d = ST_RUN;
    end
  end

  // State, window and timeout registers
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q         <= ST_RUN;
      flush_cnt_q     <= 3'd0;
      mem_cnt_q       <= 16'd0;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_cnt_q     <= flush_cnt_d;
      mem_cnt_q       <= mem_cnt_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  assign bus.halt_type     = halt_s;
  assign bus.IFID_discard  = ifid_discard_s;
  assign bus.IDEX_discard  = idex_discard_s;
  assign bus.stall_timeout = stall_timeout_q;

`ifdef PIPE_PERF_EN
  pipe_perf_cnt u_perf (
    .clk            (clk),
    .rst            (rst),
    .halt_active_i  (halt_s != HALT_RUN),
    .redirect_i     (redirect_s),
    .stall_cycles_o (bus.stall_cycles),
    .flush_count_o  (bus.flush_count)
  );
`else
  logic unused_s;
  assign unused_s = redirect_s;
`endif

endmodule
